// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline control unit and its interrupt sequencer.
package pipeline_ctrl_pkg;

  localparam int DEFAULT_DRAIN_CYCLES = 3;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_VECTOR = 2'b10;

  localparam logic [1:0] PUSH_NONE  = 2'b00;
  localparam logic [1:0] PUSH_PC    = 2'b01;
  localparam logic [1:0] PUSH_FLAGS = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_PUSH_PC    = 3'd2,
    ST_PUSH_FLAGS = 3'd3,
    ST_JUMP       = 3'd4
  } seqState_t;

  typedef struct packed {
    logic       stall;
    logic       flushIfId;
    logic       flushIdEx;
    logic [1:0] pcSel;
    logic [1:0] intPush;
    logic       intrAck;
  } seqOut_t;

  // Output pattern the sequencer drives while sitting in a given state.
  function automatic seqOut_t decodeState(input seqState_t s);
    seqOut_t o;
    o = '0;
    case (s)
      ST_DRAIN: begin
        o.stall     = 1'b1;
        o.flushIfId = 1'b1;
        o.flushIdEx = 1'b1;
      end
      ST_PUSH_PC: begin
        o.stall   = 1'b1;
        o.intPush = PUSH_PC;
      end
      ST_PUSH_FLAGS: begin
        o.stall   = 1'b1;
        o.intPush = PUSH_FLAGS;
      end
      ST_JUMP: begin
        o.pcSel     = PC_SEL_VECTOR;
        o.flushIfId = 1'b1;
        o.intrAck   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_interrupt_sequencer.sv
// Interrupt entry sequencer: intr edge detect, pending flag, drain/push/jump FSM.
module interrupt_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      intr,
  input  logic      branchTaken,
  output seqOut_t   seqOut,
  output seqState_t state
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_CYCLES - 1);

  logic             intrQ;
  logic             pending;
  logic             intrEdge;
  logic [CNT_W-1:0] count;

  assign intrEdge = intr & ~intrQ;

  // Outputs are registered from the state being entered, so they line up with state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      pending <= 1'b0;
      intrQ   <= 1'b0;
      seqOut  <= '0;
    end else begin
      intrQ <= intr;
      case (state)
        ST_IDLE: begin
          if (intrEdge) pending <= 1'b1;
          if ((pending | intrEdge) && !branchTaken) begin
            state  <= ST_DRAIN;
            count  <= '0;
            seqOut <= decodeState(ST_DRAIN);
          end else begin
            seqOut <= decodeState(ST_IDLE);
          end
        end
        ST_DRAIN: begin
          seqOut <= decodeState(ST_DRAIN);
          // A taken branch refills the pipe with the target, so draining starts over.
          if (branchTaken) begin
            count <= '0;
          end else if (count == LAST_CNT) begin
            state  <= ST_PUSH_PC;
            count  <= '0;
            seqOut <= decodeState(ST_PUSH_PC);
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_PUSH_PC: begin
          state  <= ST_PUSH_FLAGS;
          seqOut <= decodeState(ST_PUSH_FLAGS);
        end
        ST_PUSH_FLAGS: begin
          state  <= ST_JUMP;
          seqOut <= decodeState(ST_JUMP);
        end
        ST_JUMP: begin
          pending <= 1'b0;
          state   <= ST_IDLE;
          seqOut  <= decodeState(ST_IDLE);
        end
        default: begin
          state   <= ST_IDLE;
          count   <= '0;
          pending <= 1'b0;
          seqOut  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard/branch/interrupt controller: combines load-use and branch logic with the sequencer.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_branch_taken,
  input  logic                  intr,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [1:0]            pc_sel,
  output logic [1:0]            int_push,
  output logic                  intr_ack,
  output logic [2:0]            dbgState
);

  seqOut_t   seqOut;
  seqState_t seqState;
  logic      loadUse;
  logic      inIdle;
  logic      inDrain;
  logic      branchOk;

  interrupt_sequencer #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .intr       (intr),
    .branchTaken(ex_branch_taken),
    .seqOut     (seqOut),
    .state      (seqState)
  );

  assign loadUse = ex_mem_read & ex_reg_write &
                   ((id_uses_rs & (ex_rd_addr == id_rs_addr)) |
                    (id_uses_rd & (ex_rd_addr == id_rd_addr)));

  assign inIdle   = (seqState == ST_IDLE);
  assign inDrain  = (seqState == ST_DRAIN);
  // Once pushes start the pipe is empty, so only IDLE/DRAIN can see a real branch.
  assign branchOk = ex_branch_taken & (inIdle | inDrain);
  assign dbgState = seqState;

  always_comb begin
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    int_push    = PUSH_NONE;
    intr_ack    = 1'b0;
    if (!reset) begin
      stall = 1'b0;
    end else if (branchOk) begin
      pc_sel      = PC_SEL_BRANCH;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      stall       = seqOut.stall | (inIdle & loadUse);
      flush_id_ex = seqOut.flushIdEx | (inIdle & loadUse);
      flush_if_id = seqOut.flushIfId;
      pc_sel      = seqOut.pcSel;
      int_push    = seqOut.intPush;
      intr_ack    = seqOut.intrAck;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed literal checks plus a randomized run against a position-based model.
module tb_pipeline_control_unit;
  import pipeline_ctrl_pkg::*;

  localparam int AW = 4;
  localparam int D  = 3;

  localparam logic [7:0] E_NONE = 8'h00;
  localparam logic [7:0] E_LU   = 8'hA0;
  localparam logic [7:0] E_BR   = 8'h68;
  localparam logic [7:0] E_DR   = 8'hE0;
  localparam logic [7:0] E_PPC  = 8'h82;
  localparam logic [7:0] E_PFL  = 8'h84;
  localparam logic [7:0] E_JMP  = 8'h51;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] id_rs_addr = '0;
  logic [AW-1:0] id_rd_addr = '0;
  logic          id_uses_rs = 1'b0;
  logic          id_uses_rd = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic          ex_reg_write = 1'b0;
  logic [AW-1:0] ex_rd_addr = '0;
  logic          ex_branch_taken = 1'b0;
  logic          intr = 1'b0;
  logic          stall;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic [1:0]    pc_sel;
  logic [1:0]    int_push;
  logic          intr_ack;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  bit cmp_on = 1'b0;
  logic [10:0] exp_q[$];

  // model: active sequence plus position counted from the latest drain start
  bit m_prev = 1'b0;
  bit m_pend = 1'b0;
  bit m_active = 1'b0;
  int m_pos = 0;

  logic [7:0] plain_exp  [10] = '{E_NONE, E_DR, E_DR, E_DR, E_PPC, E_PFL, E_JMP, E_NONE, E_NONE, E_NONE};
  logic [7:0] branch_exp [10] = '{E_NONE, E_DR, E_BR, E_DR, E_DR, E_DR, E_PPC, E_PFL, E_JMP, E_NONE};

  pipeline_control_unit #(.REG_ADDR_W(AW), .DRAIN_CYCLES(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs_addr     (id_rs_addr),
    .id_rd_addr     (id_rd_addr),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rd     (id_uses_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_write   (ex_reg_write),
    .ex_rd_addr     (ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .intr           (intr),
    .stall          (stall),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .pc_sel         (pc_sel),
    .int_push       (int_push),
    .intr_ack       (intr_ack),
    .dbgState       (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (intr_ack) ack_cnt++;

  function automatic logic [7:0] out_vec();
    return {stall, flush_if_id, flush_id_ex, pc_sel, int_push, intr_ack};
  endfunction

  function automatic logic [10:0] model_expect();
    logic hz, idle, drain;
    logic [7:0] o;
    logic [2:0] st;
    hz = ex_mem_read & ex_reg_write &
         ((id_uses_rs & (ex_rd_addr == id_rs_addr)) | (id_uses_rd & (ex_rd_addr == id_rd_addr)));
    idle  = !m_active;
    drain = m_active && (m_pos < D);
    if (idle)               st = ST_IDLE;
    else if (drain)         st = ST_DRAIN;
    else if (m_pos == D)    st = ST_PUSH_PC;
    else if (m_pos == D+1)  st = ST_PUSH_FLAGS;
    else                    st = ST_JUMP;
    if (!reset) begin
      o  = E_NONE;
      st = ST_IDLE;
    end else if (ex_branch_taken && (idle || drain)) o = E_BR;
    else if (idle)          o = {hz, 1'b0, hz, 5'b0};
    else if (drain)         o = E_DR;
    else if (m_pos == D)    o = E_PPC;
    else if (m_pos == D+1)  o = E_PFL;
    else                    o = E_JMP;
    return {st, o};
  endfunction

  always @(posedge clk or negedge reset) begin : model_update
    bit rise;
    if (!reset) begin
      m_prev = 1'b0; m_pend = 1'b0; m_active = 1'b0; m_pos = 0;
    end else begin
      rise   = intr && !m_prev;
      m_prev = intr;
      if (!m_active) begin
        if (rise) m_pend = 1'b1;
        if (m_pend && !ex_branch_taken) begin
          m_active = 1'b1;
          m_pos = 0;
        end
      end else if (m_pos < D && ex_branch_taken) begin
        m_pos = 0;
      end else if (m_pos == D+2) begin
        m_active = 1'b0;
        m_pend = 1'b0;
      end else begin
        m_pos++;
      end
    end
  end

  // scoreboard compare, every cycle once enabled
  always @(negedge clk) begin
    if (cmp_on) begin : cmp
      logic [10:0] e, got;
      exp_q.push_back(model_expect());
      e   = exp_q.pop_front();
      got = {dbg_state, out_vec()};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL model cyc=%0d got(state,out)=%b required=%b", cyc, got, e);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_addr = '0; id_rd_addr = '0; id_uses_rs = 1'b0; id_uses_rd = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd_addr = '0; ex_branch_taken = 1'b0;
  endtask

  initial begin
    clear_inputs();
    intr = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    check_lit("reset_outputs", out_vec(), E_NONE);
    check_lit("reset_state", {5'b0, dbg_state}, {5'b0, ST_IDLE});
    reset = 1'b1;
    cmp_on = 1'b1;
    repeat (2) step();

    // load-use on rs, then no match, then branch overriding load-use
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = 4'd3;
    id_rs_addr = 4'd3; id_uses_rs = 1'b1;
    @(negedge clk); check_lit("load_use_rs", out_vec(), E_LU);
    step(); id_rs_addr = 4'd4;
    @(negedge clk); check_lit("no_hazard", out_vec(), E_NONE);
    step(); id_rs_addr = 4'd3; ex_branch_taken = 1'b1;
    @(negedge clk); check_lit("branch_over_load", out_vec(), E_BR);
    step(); clear_inputs();
    step();

    // plain interrupt entry, second edge at k=4 must be ignored
    ack_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      intr = (k < 3) || (k >= 4 && k < 8);
      @(negedge clk);
      check_lit($sformatf("intr_plain_k%0d", k), out_vec(), plain_exp[k]);
    end
    check_lit("ack_count_plain", 8'(ack_cnt), 8'd1);
    step();

    // branch during drain restarts draining
    ack_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      intr = 1'b1;
      ex_branch_taken = (k == 2);
      @(negedge clk);
      check_lit($sformatf("intr_branch_k%0d", k), out_vec(), branch_exp[k]);
    end
    check_lit("ack_count_branch", 8'(ack_cnt), 8'd1);
    step(); intr = 1'b0;
    step();

    // reset in PUSH_PC aborts the sequence
    step(); intr = 1'b1;
    repeat (4) step();
    check_lit("in_push_pc", out_vec(), E_PPC);
    #1 reset = 1'b0; intr = 1'b0;
    #1 check_lit("reset_mid_outputs", out_vec(), E_NONE);
    check_lit("reset_mid_state", {5'b0, dbg_state}, {5'b0, ST_IDLE});
    step(); reset = 1'b1;
    ack_cnt = 0;
    repeat (10) step();
    check_lit("no_retry_ack", 8'(ack_cnt), 8'd0);
    check_lit("idle_after_reset", {5'b0, dbg_state}, {5'b0, ST_IDLE});

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_reg_write    = 1'($urandom_range(0, 1));
      ex_rd_addr      = 4'($urandom_range(0, 3));
      id_rs_addr      = 4'($urandom_range(0, 3));
      id_rd_addr      = 4'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rd      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) intr = ~intr;
      reset = ($urandom_range(0, 399) != 0);
    end
    step();
    reset = 1'b1;
    step();
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central hazard and sequencing controller for the 5-stage pipeline. It detects load-use hazards and generates stall and bubble signals. It also applies branch-resolution flushes from EX. It owns the interrupt entry sequence (drain, push PC, push flags, vector jump), driving the fetch stage's `stall` and PC-select and the IF/ID and ID/EX flush inputs.

## Interface
- `REG_ADDR_W`, 4, register address width (matches decode/buffer address fields)
- `DRAIN_CYCLES`, 3, bubble cycles inserted before interrupt pushes (EX+MEM+WB drain)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
- `id_rs_addr`  in  REG_ADDR_W  source register of instruction in ID
- `id_rd_addr`  in  REG_ADDR_W  destination-as-operand register of instruction in ID
- `id_uses_rs`, `id_uses_rd`  in  1 each  operand valid flags from decode
- `ex_mem_read`  in  1  ID/EX MemRead of instruction in EX
- `ex_reg_write`  in  1  ID/EX RegWrite of instruction in EX
- `ex_rd_addr`  in  REG_ADDR_W  ID/EX destination address
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX this cycle
- `intr`  in  1  external interrupt request, level, sampled on rising edge
- `stall`  out  1  freeze PC and IF/ID
- `flush_if_id`  out  1  clear IF/ID to NOP
- `flush_id_ex`  out  1  insert bubble into ID/EX (all control bits 0)
- `pc_sel`  out  2  00 sequential, 01 branch target, 10 interrupt vector
- `int_push`  out  2  00 none, 01 push PC, 10 push flags (to memory stage SP logic)
- `intr_ack`  out  1  one-cycle pulse on vector jump

## Operation
- Load-use hazard: `ex_mem_read & ex_reg_write & ((id_uses_rs & ex_rd_addr==id_rs_addr) | (id_uses_rd & ex_rd_addr==id_rd_addr))` → `stall=1`, `flush_id_ex=1`; combinational, same cycle.
- Branch: `ex_branch_taken` → `pc_sel=01`, `flush_if_id=1`, `flush_id_ex=1`, `stall=0`; overrides load-use in the same cycle.
- Interrupt pending flop: set on rising edge of `intr` (registered previous value); further edges ignored while pending or sequencing; cleared in JUMP.
- FSM states: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, JUMP.
  - IDLE → DRAIN when pending & !ex_branch_taken; drain counter ← 0.
  - DRAIN: `stall=1`, `flush_if_id=1`, `flush_id_ex=1`; counter increments; → PUSH_PC when counter == DRAIN_CYCLES-1.
  - DRAIN with ex_branch_taken: branch outputs apply (`stall=0`, `pc_sel=01`) so the saved PC is the target; counter restarts at 0.
  - PUSH_PC: `int_push=01`, `stall=1` → PUSH_FLAGS.
  - PUSH_FLAGS: `int_push=10`, `stall=1` → JUMP.
  - JUMP: `pc_sel=10`, `flush_if_id=1`, `intr_ack=1`, pending ← 0 → IDLE.
- Hazard detection is masked outside IDLE, because decode only holds bubbles then.

## Timing
- Reset values: state IDLE, counter 0, pending 0, edge-detect flop 0. Outputs: `stall=0`, both flushes 0, `pc_sel=00`, `int_push=00`, `intr_ack=0`.
- Load-use and branch responses are zero-latency combinational. A load-use stall lasts exactly 1 cycle because the load advances to MEM.
- Interrupt latency with no branches, from the `intr` edge cycle T:
  - pending at T+1; DRAIN T+1..T+3.
  - PUSH_PC T+4; PUSH_FLAGS T+5; JUMP T+6; IDLE at T+7.
- `intr` edge in the same cycle as JUMP is ignored (pending cleared wins).
- Reset mid-sequence aborts to IDLE; a partial push is not retried.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state enum
  - `PC_SEL_SEQ/BRANCH/VECTOR` encodings
  - `PUSH_NONE/PC/FLAGS` encodings
  - default `DRAIN_CYCLES`
- One natural sub-module: `interrupt_sequencer` (pending flop, FSM, drain counter). The top handles combinational hazard/branch logic and priority muxing of outputs.

## Test plan
- Load r3 in EX (`ex_mem_read=1`, `ex_rd_addr=3`), ID `id_rs_addr=3`, `id_uses_rs=1` → `stall=1`, `flush_id_ex=1` for 1 cycle; `id_rs_addr=4` → no stall.
- Load-use and `ex_branch_taken=1` same cycle → `stall=0`, `pc_sel=01`, both flushes 1.
- `intr` rises at cycle 10, no branches → DRAIN 11–13, `int_push=01` at 14, `10` at 15, `pc_sel=10`+`intr_ack` at 16, IDLE at 17.
- `ex_branch_taken` at cycle 12 during DRAIN → `pc_sel=01`, `stall=0` at 12; drain restarts, `intr_ack` at cycle 18.
- Second `intr` edge at cycle 14 while sequencing → ignored; exactly one `intr_ack`.
- `reset=0` in PUSH_PC → all outputs 0 immediately, state IDLE, pending 0 after release.
